// File: rtl/dcache_pkg.sv
// Shared types and sizes for the direct-mapped write-back data cache.
package dcache_pkg;
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_W         = 32;
  localparam int LINE_W         = WORDS_PER_LINE * WORD_W;
  localparam int ADDR_W         = 30;
  localparam int MEM_ADDR_W     = 28;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  // Word 0 sits in the least significant 32 bits of a line.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [1:0]        sel);
    return line[{sel, 5'd0} +: WORD_W];
  endfunction
endpackage

// File: rtl/dcache_array.sv
// Storage for the cache: valid/dirty bits (reset), tags and line data (no reset).
module dcache_array
  import dcache_pkg::*;
#(
  parameter  int LINES = 8,
  localparam int IW    = $clog2(LINES),
  localparam int TAG_W = MEM_ADDR_W - IW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IW-1:0]     idx_i,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [LINE_W-1:0] line_o,
  input  logic              word_we_i,
  input  logic [1:0]        word_sel_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              fill_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [LINE_W-1:0] fill_line_i
);
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  // A fill leaves the line clean; a word store marks it dirty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data updates; these arrays are qualified by valid so need no reset.
  always_ff @(posedge clk_i) begin
    if (fill_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      data_q[idx_i] <= fill_line_i;
    end else if (word_we_i) begin
      data_q[idx_i][{word_sel_i, 5'd0} +: WORD_W] <= word_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];
endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache between the core and 128-bit memory.
module dcache
  import dcache_pkg::*;
#(
  parameter int LINES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  DCACHE_ren,
  input  logic                  DCACHE_wen,
  input  logic [ADDR_W-1:0]     DCACHE_addr,
  input  logic [WORD_W-1:0]     DCACHE_wdata,
  output logic                  DCACHE_stall,
  output logic [WORD_W-1:0]     DCACHE_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]     mem_wdata,
  input  logic [LINE_W-1:0]     mem_rdata,
  input  logic                  mem_ready
);
  localparam int IW    = $clog2(LINES);
  localparam int TAG_W = MEM_ADDR_W - IW;

  state_e             state_q;
  state_e             state_d;
  logic [IW-1:0]      idx_s;
  logic [TAG_W-1:0]   req_tag_s;
  logic [1:0]         word_sel_s;
  logic               line_valid_s;
  logic               line_dirty_s;
  logic [TAG_W-1:0]   line_tag_s;
  logic [LINE_W-1:0]  line_data_s;
  logic               hit_s;
  logic               req_s;
  logic               idle_hit_s;
  logic               word_we_s;
  logic               fill_s;

  assign word_sel_s = DCACHE_addr[1:0];
  assign idx_s      = DCACHE_addr[IW+1:2];
  assign req_tag_s  = DCACHE_addr[ADDR_W-1:IW+2];
  assign hit_s      = line_valid_s && (line_tag_s == req_tag_s);
  assign req_s      = DCACHE_ren || DCACHE_wen;
  assign idle_hit_s = (state_q == IDLE) && hit_s;

  assign DCACHE_stall = req_s && !idle_hit_s;
  // Write wins when both ren and wen are raised; reset suppresses any array update.
  assign word_we_s = idle_hit_s && DCACHE_wen && !rst;
  assign fill_s    = (state_q == ALLOCATE) && mem_ready && !rst;

  dcache_array #(.LINES(LINES)) u_array (
    .clk_i       (clk),
    .rst_i       (rst),
    .idx_i       (idx_s),
    .valid_o     (line_valid_s),
    .dirty_o     (line_dirty_s),
    .tag_o       (line_tag_s),
    .line_o      (line_data_s),
    .word_we_i   (word_we_s),
    .word_sel_i  (word_sel_s),
    .word_i      (DCACHE_wdata),
    .fill_i      (fill_s),
    .fill_tag_i  (req_tag_s),
    .fill_line_i (mem_rdata)
  );

  // Miss handling: write back a dirty victim first, then refill the requested line.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_s && !hit_s) begin
          if (line_valid_s && line_dirty_s) begin
            state_d = WRITEBACK;
          end else begin
            state_d = ALLOCATE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITEBACK: begin
        if (mem_ready) begin
          state_d = ALLOCATE;
        end else begin
          state_d = WRITEBACK;
        end
      end
      ALLOCATE: begin
        if (mem_ready) begin
          state_d = IDLE;
        end else begin
          state_d = ALLOCATE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset takes priority over a coincident mem_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory request outputs are decoded from state so they stay stable while waiting.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {line_tag_s, idx_s};
        mem_wdata = line_data_s;
      end
      ALLOCATE: begin
        mem_read = 1'b1;
        mem_addr = DCACHE_addr[ADDR_W-1:2];
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
  end

  // Load data is driven only for a read that hits while idle.
  always_comb begin
    DCACHE_rdata = '0;
    if (DCACHE_ren && idle_hit_s) begin
      DCACHE_rdata = line_word(line_data_s, word_sel_s);
    end else begin
      DCACHE_rdata = '0;
    end
  end
endmodule

// File: tb/tb_dcache.sv
// Directed self-checking bench for dcache with LINES=8.
module tb_dcache;
  logic         clk;
  logic         rst;
  logic         ren;
  logic         wen;
  logic [29:0]  addr;
  logic [31:0]  wdata;
  logic         stall;
  logic [31:0]  rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0]  WA    = 32'hAAAA0000;
  localparam logic [31:0]  WB    = 32'hBBBB1111;
  localparam logic [31:0]  WC    = 32'hCCCC2222;
  localparam logic [31:0]  WD    = 32'hDDDD3333;
  localparam logic [127:0] LINE1 = {WD, WC, WB, WA};
  localparam logic [127:0] LINE2 = {32'h20000003, 32'h20000002, 32'h20000001, 32'h20000000};
  localparam logic [127:0] LINE3 = {32'h30000003, 32'h30000002, 32'h30000001, 32'h30000000};

  dcache #(.LINES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .DCACHE_ren   (ren),
    .DCACHE_wen   (wen),
    .DCACHE_addr  (addr),
    .DCACHE_wdata (wdata),
    .DCACHE_stall (stall),
    .DCACHE_rdata (rdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_mread", mem_read, 1'b0);
    chk("rst_mwrite", mem_write, 1'b0);
    chk("rst_maddr", mem_addr, 28'h0);
    chk("rst_mwdata", mem_wdata, 128'h0);
    chk("rst_rdata", rdata, 32'h0);

    // clean miss on 0x10, refill after 3 cycles
    @(negedge clk); ren = 1'b1; addr = 30'h10; #1;
    chk("miss_stall", stall, 1'b1);
    chk("miss_cycle_mread", mem_read, 1'b0);
    @(negedge clk); #1;
    chk("alloc_mread", mem_read, 1'b1);
    chk("alloc_maddr", mem_addr, 28'h4);
    chk("alloc_mwrite", mem_write, 1'b0);
    chk("alloc_stall", stall, 1'b1);
    @(negedge clk); #1;
    chk("wait_stall", stall, 1'b1);
    @(negedge clk); mem_ready = 1'b1; mem_rdata = LINE1; #1;
    chk("ready_cycle_stall", stall, 1'b1);
    @(negedge clk); mem_ready = 1'b0; mem_rdata = '0; #1;
    chk("refill_stall", stall, 1'b0);
    chk("refill_rdata", rdata, WA);
    chk("refill_mread", mem_read, 1'b0);

    // hit on word 3
    @(negedge clk); addr = 30'h13; #1;
    chk("hit_stall", stall, 1'b0);
    chk("hit_rdata", rdata, WD);
    chk("hit_mread", mem_read, 1'b0);
    chk("hit_mwrite", mem_write, 1'b0);

    // write hit then read back
    @(negedge clk); ren = 1'b0; wen = 1'b1; addr = 30'h11; wdata = 32'hDEADBEEF; #1;
    chk("whit_stall", stall, 1'b0);
    @(negedge clk); wen = 1'b0; ren = 1'b1; #1;
    chk("whit_readback", rdata, 32'hDEADBEEF);
    chk("whit_mwrite", mem_write, 1'b0);

    // stray mem_ready while idle
    @(negedge clk); ren = 1'b0; mem_ready = 1'b1; #1;
    chk("idle_stall", stall, 1'b0);
    chk("idle_rdata", rdata, 32'h0);
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("idle_ready_mread", mem_read, 1'b0);
    chk("idle_ready_mwrite", mem_write, 1'b0);

    // dirty miss on 0x30 (same index, tag 1)
    @(negedge clk); ren = 1'b1; addr = 30'h30; #1;
    chk("dmiss_stall", stall, 1'b1);
    chk("dmiss_mwrite_idle", mem_write, 1'b0);
    @(negedge clk); #1;
    chk("wb_mwrite", mem_write, 1'b1);
    chk("wb_mread", mem_read, 1'b0);
    chk("wb_maddr", mem_addr, 28'h4);
    chk("wb_word1", mem_wdata[63:32], 32'hDEADBEEF);
    chk("wb_line", mem_wdata, {WD, WC, 32'hDEADBEEF, WA});
    @(negedge clk); #1;
    chk("wb_hold_mwrite", mem_write, 1'b1);
    chk("wb_hold_line", mem_wdata, {WD, WC, 32'hDEADBEEF, WA});
    mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("wb2alloc_mread", mem_read, 1'b1);
    chk("wb2alloc_mwrite", mem_write, 1'b0);
    chk("wb2alloc_maddr", mem_addr, 28'hC);
    mem_ready = 1'b1; mem_rdata = LINE2;
    @(negedge clk); mem_ready = 1'b0; mem_rdata = '0; #1;
    chk("dmiss_done_stall", stall, 1'b0);
    chk("dmiss_done_rdata", rdata, 32'h20000000);

    // reset during allocate of 0x50, with coincident mem_ready
    @(negedge clk); addr = 30'h50; #1;
    chk("rmiss_stall", stall, 1'b1);
    @(negedge clk); #1;
    chk("rmiss_mread", mem_read, 1'b1);
    chk("rmiss_mwrite", mem_write, 1'b0);
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = LINE3;
    @(negedge clk); rst = 1'b0; mem_ready = 1'b0; mem_rdata = '0; ren = 1'b0; #1;
    chk("rst_abort_mread", mem_read, 1'b0);
    chk("rst_abort_stall", stall, 1'b0);
    chk("rst_abort_maddr", mem_addr, 28'h0);
    @(negedge clk); ren = 1'b1; addr = 30'h50; #1;
    chk("rst_remiss_stall", stall, 1'b1);
    @(negedge clk); #1;
    chk("rst_remiss_mread", mem_read, 1'b1);
    chk("rst_remiss_mwrite", mem_write, 1'b0);
    chk("rst_remiss_maddr", mem_addr, 28'h14);
    mem_ready = 1'b1; mem_rdata = LINE3;
    @(negedge clk); mem_ready = 1'b0; mem_rdata = '0; #1;
    chk("rst_remiss_stall_done", stall, 1'b0);
    chk("rst_remiss_rdata", rdata, 32'h30000000);

    // ren & wen together to 0x12: miss, refill, then stored as a write
    @(negedge clk); wen = 1'b1; addr = 30'h12; wdata = 32'h12345678; #1;
    chk("rw_miss_stall", stall, 1'b1);
    @(negedge clk); #1;
    chk("rw_alloc_mread", mem_read, 1'b1);
    chk("rw_alloc_maddr", mem_addr, 28'h4);
    chk("rw_alloc_mwrite", mem_write, 1'b0);
    mem_ready = 1'b1; mem_rdata = LINE1;
    @(negedge clk); mem_ready = 1'b0; mem_rdata = '0; #1;
    chk("rw_hit_stall", stall, 1'b0);
    @(negedge clk); wen = 1'b0; #1;
    chk("rw_readback", rdata, 32'h12345678);
    chk("rw_readback_stall", stall, 1'b0);
    @(negedge clk); addr = 30'h10; #1;
    chk("rw_word0", rdata, WA);

    // evict the line just written: victim must carry the stored word
    @(negedge clk); addr = 30'h50; #1;
    chk("rw_evict_stall", stall, 1'b1);
    @(negedge clk); #1;
    chk("rw_evict_mwrite", mem_write, 1'b1);
    chk("rw_evict_line", mem_wdata, {WD, 32'h12345678, WB, WA});

    @(negedge clk); rst = 1'b1; ren = 1'b0;
    @(negedge clk); rst = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-back, write-allocate data cache between the pipelined core's D-cache port and the slow 128-bit main memory. It is the responder to the core's `DCACHE_*` request interface: it serves hits in the same cycle and raises `DCACHE_stall` while it writes back a dirty victim line and refills from memory. Word data passes through unmodified; byte-order swapping stays in the core.

## Interface
- `LINES`, 8: number of cache lines (power of two, ≥2). Index width `IW = log2(LINES)`.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `DCACHE_ren` input 1: core read request.
- `DCACHE_wen` input 1: core write request (full 32-bit word).
- `DCACHE_addr` input 30: word address; `[1:0]` word-in-line, `[IW+1:2]` index, `[29:IW+2]` tag.
- `DCACHE_wdata` input 32: store data.
- `DCACHE_stall` output 1: high while a request cannot complete this cycle.
- `DCACHE_rdata` output 32: load data, valid when `ren` and not `stall`.
- `mem_read` output 1: line refill request.
- `mem_write` output 1: line write-back request.
- `mem_addr` output 28: line address (word address >> 2).
- `mem_wdata` output 128: victim line, word 0 in `[31:0]`.
- `mem_rdata` input 128: refill line, same packing.
- `mem_ready` input 1: one-cycle pulse completing the current mem request.

## Operation
- Per line: valid, dirty, tag (`28-IW` bits), 4×32 data.
- States: `IDLE`, `WRITEBACK`, `ALLOCATE`.
- `IDLE`, no request: stall low, no memory activity.
- `IDLE`, hit (valid & tag match): read returns word combinationally; write updates word and sets dirty at the next edge; stall low.
- `IDLE`, miss, victim clean or invalid → `ALLOCATE`; miss, victim valid & dirty → `WRITEBACK`. `stall` is high in the miss cycle.
- `WRITEBACK`: `mem_write`=1, `mem_addr`={victim tag, index}, `mem_wdata`=victim line, held stable; on `mem_ready` → `ALLOCATE`.
- `ALLOCATE`: `mem_read`=1, `mem_addr`=`DCACHE_addr[29:2]`; on `mem_ready` write line, valid=1, dirty=0, tag set → `IDLE`. The request now hits and completes (write hit sets dirty).
- `mem_read` and `mem_write` are never high together.
- `ren` & `wen` together: treated as a write.
- Core holds addr/ren/wen/wdata stable while stall is high; cache behaviour is unspecified otherwise.
- Reset: all valid and dirty cleared, state `IDLE`. Data and tag arrays need no reset.

## Timing
- Outputs after reset: `DCACHE_stall`=0 with no request, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, `DCACHE_rdata`=0 when not reading.
- `DCACHE_stall` is combinational: `(ren|wen) & !(state==IDLE & hit)`.
- Hit latency: 0 extra cycles.
- Clean-miss latency: miss cycle + refill wait N cycles until `mem_ready` + 1 hit cycle. Stall is high for N+1 cycles when `mem_ready` arrives N cycles after `mem_read` rises.
- Dirty miss: adds the write-back wait before `ALLOCATE`.
- `mem_ready` outside `WRITEBACK`/`ALLOCATE` is ignored.
- `rst` mid-`WRITEBACK`/`ALLOCATE`: the next edge returns to `IDLE` and mem requests drop. The abandoned line is not written, and valid is cleared.
- `rst` takes priority over a simultaneous `mem_ready`.

## Structure
- Package `dcache_pkg`: state enum (`IDLE`, `WRITEBACK`, `ALLOCATE`), `WORDS_PER_LINE=4`, `LINE_W=128`, `ADDR_W=30`, `MEM_ADDR_W=28`.
- Sub-module `dcache_array`:
  - holds valid/dirty/tag/data;
  - combinational read by index;
  - write ports for word update and full-line fill.
- Top holds the FSM, hit compare and muxing.

## Test plan
- After reset, read `0x0000010` → stall high. `mem_read`=1, `mem_addr`=`0x0000004`. Return line `{D,C,B,A}` with `mem_ready` after 3 cycles → stall drops the next cycle and `rdata`=A (word 0).
- Immediately read `0x0000013` → hit, stall 0 in the same cycle, `rdata`=D. No mem activity.
- Write `0x0000011`=`0xDEADBEEF` (hit) → no stall. Read back `0x0000011` → `0xDEADBEEF`; `mem_write` stays 0.
- Read `0x0000030` (same index 4 with `LINES`=8, different tag):
  - `mem_write`=1, `mem_addr`=`0x0000004`, `mem_wdata[63:32]`=`0xDEADBEEF`;
  - after `mem_ready`, `mem_read` with `mem_addr`=`0x000000C`;
  - the read then completes.
- Clean miss with `rst` asserted while `mem_read`=1 → next cycle `mem_read`=0, stall 0 when idle. A re-read of the same address misses again.
- Simultaneous `ren`&`wen` hit to `0x0000012` with `0x12345678` → stored. A later read returns `0x12345678`.
